// File: rtl/letc_core_muldiv_if.sv
// letc_core_muldiv_if: request/response handshake bundle for the iterative multiply/divide unit
interface letc_core_muldiv_if #(parameter int WIDTH = 32);
    logic                   flush;
    logic                   req_valid;
    logic                   req_ready;
    logic [2:0]             op;
    logic [1:0][WIDTH-1:0]  operands;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       result;
    modport master (output flush, req_valid, op, operands, rsp_ready, input req_ready, rsp_valid, result);
    modport slave (input flush, req_valid, op, operands, rsp_ready, output req_ready, rsp_valid, result);
endinterface

// File: rtl/letc_core_muldiv.sv
// letc_core_muldiv: iterative 1-bit-per-cycle shift-add multiply / restoring divide unit
module letc_core_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    letc_core_muldiv_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
    localparam int CW = $clog2(WIDTH);
    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic               neg_q;
    logic [WIDTH-1:0]   opb, result, rs1, rs2, mag1, mag2, addend, quo_s, rem_s, fin, spec_res;
    logic [2*WIDTH-1:0] acc, acc_nx, prod_s;
    logic [WIDTH:0]     add_s, trial, diff;
    logic               is_div, is_rem, sign1, sign2, div0, ovf, bypass, accept, last;
    assign rs1      = bus.operands[0];
    assign rs2      = bus.operands[1];
    assign is_div   = bus.op[2];
    assign is_rem   = bus.op[1];
    assign sign1    = rs1[WIDTH-1] && (is_div ? !bus.op[0] : (bus.op == 3'd1 || bus.op == 3'd2));
    assign sign2    = rs2[WIDTH-1] && (is_div ? !bus.op[0] : bus.op == 3'd1);
    assign mag1     = sign1 ? -rs1 : rs1;
    assign mag2     = sign2 ? -rs2 : rs2;
    assign div0     = is_div && rs2 == '0;
    assign ovf      = is_div && !bus.op[0] && rs1 == {1'b1, {(WIDTH-1){1'b0}}} && &rs2;
    assign bypass   = div0 || ovf;
    assign spec_res = div0 ? (is_rem ? rs1 : '1) : (is_rem ? '0 : rs1);
    assign accept   = bus.req_valid && state == IDLE && !bus.flush;
    assign last     = cnt == CW'(WIDTH - 1);
    // acc holds {hi, lo}: multiply shifts right accumulating into hi; divide shifts left with hi as remainder
    assign addend   = acc[0] ? opb : '0;
    assign add_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff     = trial - {1'b0, opb};
    assign acc_nx   = !op_q[2] ? {add_s, acc[WIDTH-1:1]} :
                      diff[WIDTH] ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                      {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign prod_s   = neg_q ? -acc_nx : acc_nx;
    assign quo_s    = acc_nx[WIDTH-1:0];
    assign rem_s    = acc_nx[2*WIDTH-1:WIDTH];
    assign fin      = !op_q[2] ? (op_q[1:0] == 2'd0 ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH]) :
                      op_q[1] ? (neg_q ? -rem_s : rem_s) : (neg_q ? -quo_s : quo_s);
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            opb    <= '0;
            acc    <= '0;
            result <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (accept) begin
            op_q  <= bus.op;
            neg_q <= (is_div && is_rem) ? sign1 : sign1 ^ sign2;
            opb   <= is_div ? mag2 : mag1;
            acc   <= {{WIDTH{1'b0}}, is_div ? mag1 : mag2};
            state <= bypass ? DONE : CALC;
            if (bypass)
                result <= spec_res;
        end else if (state == CALC) begin
            acc <= acc_nx;
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
                state  <= DONE;
                result <= fin;
            end
        end else if (state == DONE && bus.rsp_ready) begin
            state <= IDLE;
        end
    end
    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == DONE;
    assign bus.result    = result;
endmodule
